// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and screen constants for the sprite animation controller
package sprite_pkg;

   typedef enum logic [1:0] {
      DIR_DOWN  = 2'd0,
      DIR_UP    = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic {
      ST_IDLE,
      ST_WALK
   } anim_state_t;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

endpackage

// File: rtl/sprite_anim_ctrl_if.sv
// rtl/sprite_anim_ctrl_if.sv - player input and sprite state bundle
interface sprite_anim_ctrl_if;

   logic       frame_tick;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic [1:0] start;
   logic [1:0] step;
   logic       moving;
   logic [9:0] pos_x;
   logic [9:0] pos_y;

   modport master (
      output frame_tick, btn_up, btn_down, btn_left, btn_right,
      input  start, step, moving, pos_x, pos_y
   );

   modport slave (
      input  frame_tick, btn_up, btn_down, btn_left, btn_right,
      output start, step, moving, pos_x, pos_y
   );

endinterface

// File: rtl/sprite_anim_ctrl_btn_sync.sv
// rtl/sprite_anim_ctrl_btn_sync.sv - button synchronizers and direction priority encoder
module btn_sync
   import sprite_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_left,
   input  logic btn_right,
   output logic req_valid,
   output dir_t req_dir
);

   // bit order: {right, left, down, up}
   logic [3:0] meta_q;
   logic [3:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 4'b0000;
         sync_q <= 4'b0000;
      end else begin
         meta_q <= {btn_right, btn_left, btn_down, btn_up};
         sync_q <= meta_q;
      end
   end

   assign req_valid = |sync_q;

   always_comb begin
      req_dir = DIR_RIGHT;
      if (sync_q[0])
         req_dir = DIR_UP;
      else if (sync_q[1])
         req_dir = DIR_DOWN;
      else if (sync_q[2])
         req_dir = DIR_LEFT;
   end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// rtl/sprite_anim_ctrl.sv - frame-locked walk FSM producing direction, animation step and clamped position
module sprite_anim_ctrl
   import sprite_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 8,
   parameter int SPEED           = 2,
   parameter int SPRITE_W        = 32,
   parameter int SPRITE_H        = 32,
   parameter int X_INIT          = 304,
   parameter int Y_INIT          = 224
) (
   input  logic             clk,
   input  logic             reset,
   sprite_anim_ctrl_if.slave bus
);

   localparam logic [0:0] S_IDLE = ST_IDLE;
   localparam logic [0:0] S_WALK = ST_WALK;

   localparam int X_LIM    = H_ACTIVE - SPRITE_W;
   localparam int Y_LIM    = V_ACTIVE - SPRITE_H;
   localparam int DIV_LIM  = FRAMES_PER_STEP - 1;

   localparam logic signed [10:0] X_MAX    = X_LIM[10:0];
   localparam logic signed [10:0] Y_MAX    = Y_LIM[10:0];
   localparam logic signed [10:0] SPD      = SPEED[10:0];
   localparam logic [7:0]         DIV_LAST = DIV_LIM[7:0];
   localparam logic [9:0]         X_RST    = X_INIT[9:0];
   localparam logic [9:0]         Y_RST    = Y_INIT[9:0];

   logic       req_valid;
   dir_t       req_dir;

   logic [0:0] state_q;
   dir_t       start_q;
   logic [1:0] step_q;
   logic [7:0] div_q;
   logic [9:0] pos_x_q;
   logic [9:0] pos_y_q;

   logic signed [10:0] cur_x;
   logic signed [10:0] cur_y;
   logic signed [10:0] nx;
   logic signed [10:0] ny;
   logic [9:0]         mv_x;
   logic [9:0]         mv_y;

   btn_sync u_btn_sync (
      .clk       (clk),
      .reset     (reset),
      .btn_up    (bus.btn_up),
      .btn_down  (bus.btn_down),
      .btn_left  (bus.btn_left),
      .btn_right (bus.btn_right),
      .req_valid (req_valid),
      .req_dir   (req_dir)
   );

   function automatic logic [9:0] clamp(input logic signed [10:0] v,
                                        input logic signed [10:0] hi);
      if (v < 11'sd0)
         return 10'd0;
      else if (v > hi)
         return hi[9:0];
      else
         return v[9:0];
   endfunction

   assign cur_x = signed'({1'b0, pos_x_q});
   assign cur_y = signed'({1'b0, pos_y_q});

   // Candidate position one step in the requested direction, saturated to the active area
   always_comb begin
      nx = cur_x;
      ny = cur_y;
      case (req_dir)
         DIR_UP:    ny = cur_y - SPD;
         DIR_DOWN:  ny = cur_y + SPD;
         DIR_LEFT:  nx = cur_x - SPD;
         DIR_RIGHT: nx = cur_x + SPD;
         default:   nx = cur_x;
      endcase
      mv_x = clamp(nx, X_MAX);
      mv_y = clamp(ny, Y_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         start_q <= DIR_DOWN;
         step_q  <= 2'd0;
         div_q   <= 8'd0;
         pos_x_q <= X_RST;
         pos_y_q <= Y_RST;
      end else if (bus.frame_tick) begin
         if (state_q == S_IDLE) begin
            step_q <= 2'd0;
            if (req_valid) begin
               state_q <= S_WALK;
               start_q <= req_dir;
               div_q   <= 8'd0;
               pos_x_q <= mv_x;
               pos_y_q <= mv_y;
            end
         end else begin
            if (!req_valid) begin
               // Facing direction is kept so the idle sprite looks where it last walked
               state_q <= S_IDLE;
               step_q  <= 2'd0;
               div_q   <= 8'd0;
            end else if (req_dir != start_q) begin
               start_q <= req_dir;
               step_q  <= 2'd0;
               div_q   <= 8'd0;
               pos_x_q <= mv_x;
               pos_y_q <= mv_y;
            end else begin
               if (div_q == DIV_LAST) begin
                  div_q  <= 8'd0;
                  step_q <= step_q + 2'd1;
               end else begin
                  div_q  <= div_q + 8'd1;
               end
               pos_x_q <= mv_x;
               pos_y_q <= mv_y;
            end
         end
      end
   end

   assign bus.start  = start_q;
   assign bus.step   = step_q;
   assign bus.moving = (state_q == S_WALK);
   assign bus.pos_x  = pos_x_q;
   assign bus.pos_y  = pos_y_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// tb/tb_sprite_anim_ctrl.sv - scoreboard bench for sprite_anim_ctrl
module tb_sprite_anim_ctrl;

   localparam int FPS   = 8;
   localparam int SPEED = 2;
   localparam int XMAX  = 640 - 32;
   localparam int YMAX  = 480 - 32;

   typedef struct packed {
      logic [1:0] start;
      logic [1:0] step;
      logic       moving;
      logic [9:0] x;
      logic [9:0] y;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sprite_anim_ctrl_if bus ();

   sprite_anim_ctrl #(
      .FRAMES_PER_STEP (FPS),
      .SPEED           (SPEED),
      .SPRITE_W        (32),
      .SPRITE_H        (32),
      .X_INIT          (304),
      .Y_INIT          (224)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   obs_t q[$];

   int m_walk, m_start, m_step, m_div, m_x, m_y;

   function automatic void model_reset();
      m_walk = 0; m_start = 0; m_step = 0; m_div = 0; m_x = 304; m_y = 224;
   endfunction

   function automatic void model_move(input int dir);
      case (dir)
         1: m_y = (m_y - SPEED < 0) ? 0 : m_y - SPEED;
         0: m_y = (m_y + SPEED > YMAX) ? YMAX : m_y + SPEED;
         2: m_x = (m_x - SPEED < 0) ? 0 : m_x - SPEED;
         default: m_x = (m_x + SPEED > XMAX) ? XMAX : m_x + SPEED;
      endcase
   endfunction

   function automatic void model_tick();
      logic v;
      int d;
      v = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
      d = bus.btn_up ? 1 : bus.btn_down ? 0 : bus.btn_left ? 2 : 3;
      if (reset) begin
         model_reset();
      end else if (m_walk == 0) begin
         m_step = 0;
         if (v) begin
            m_walk = 1; m_start = d; m_div = 0; model_move(d);
         end
      end else if (!v) begin
         m_walk = 0; m_step = 0; m_div = 0;
      end else if (d != m_start) begin
         m_start = d; m_step = 0; m_div = 0; model_move(d);
      end else begin
         if (m_div == FPS - 1) begin
            m_div = 0; m_step = (m_step + 1) % 4;
         end else begin
            m_div = m_div + 1;
         end
         model_move(d);
      end
   endfunction

   function automatic obs_t model_obs();
      return {2'(m_start), 2'(m_step), 1'(m_walk), 10'(m_x), 10'(m_y)};
   endfunction

   function automatic obs_t dut_obs();
      return {bus.start, bus.step, bus.moving, bus.pos_x, bus.pos_y};
   endfunction

   task automatic set_btns(input logic u, input logic d, input logic l, input logic r);
      @(posedge clk); #1;
      bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
      repeat (3) @(posedge clk);
   endtask

   task automatic do_tick(input string tag);
      obs_t exp, act;
      @(posedge clk); #1;
      bus.frame_tick = 1'b1;
      model_tick();
      q.push_back(model_obs());
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      exp = q.pop_front();
      act = dut_obs();
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s tick: got start=%0d step=%0d moving=%0d x=%0d y=%0d, expected start=%0d step=%0d moving=%0d x=%0d y=%0d",
                  tag, act.start, act.step, act.moving, act.x, act.y,
                  exp.start, exp.step, exp.moving, exp.x, exp.y);
      end
      repeat (2) @(posedge clk); #1;
      act = dut_obs();
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s hold: got start=%0d step=%0d moving=%0d x=%0d y=%0d, expected start=%0d step=%0d moving=%0d x=%0d y=%0d",
                  tag, act.start, act.step, act.moving, act.x, act.y,
                  exp.start, exp.step, exp.moving, exp.x, exp.y);
      end
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      reset = 1'b1;
      bus.frame_tick = 1'b0;
      bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
      repeat (3) @(posedge clk); #1;
      model_reset();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      obs_t rst_val;
      rst_val = {2'd0, 2'd0, 1'b0, 10'd304, 10'd224};
      reset_dut();
      n_tests++;
      if (dut_obs() !== rst_val) begin
         n_fail++;
         $display("FAIL reset_values: got %h, expected %h", dut_obs(), rst_val);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      set_btns(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) do_tick("reset_hold");
      n_tests++;
      if (dut_obs() !== rst_val) begin
         n_fail++;
         $display("FAIL reset_over_tick: got %h, expected %h", dut_obs(), rst_val);
      end
      reset_dut();
   endtask

   task automatic test_walk_right();
      reset_dut();
      set_btns(0, 0, 0, 1);
      for (int i = 1; i <= 17; i++) begin
         do_tick("walk_right");
         if (i == 1) begin
            n_tests++;
            if (bus.moving !== 1'b1) begin
               n_fail++; $display("FAIL right_moving: got %0d, expected 1", bus.moving);
            end
         end
         if (i == 9) begin
            n_tests++;
            if (bus.step !== 2'd1) begin
               n_fail++; $display("FAIL right_step9: got %0d, expected 1", bus.step);
            end
         end
      end
      n_tests++;
      if (bus.step !== 2'd2 || bus.pos_x !== 10'd338 || bus.pos_y !== 10'd224) begin
         n_fail++;
         $display("FAIL right_tick17: got step=%0d x=%0d y=%0d, expected step=2 x=338 y=224",
                  bus.step, bus.pos_x, bus.pos_y);
      end
   endtask

   task automatic test_wall_left();
      int exp_x[5] = '{2, 0, 0, 0, 0};
      reset_dut();
      set_btns(0, 0, 1, 0);
      for (int i = 0; i < 150; i++) do_tick("left_approach");
      n_tests++;
      if (bus.pos_x !== 10'd4) begin
         n_fail++; $display("FAIL left_at4: got %0d, expected 4", bus.pos_x);
      end
      for (int i = 0; i < 5; i++) begin
         do_tick("left_wall");
         n_tests++;
         if (bus.pos_x !== 10'(exp_x[i]) || bus.moving !== 1'b1) begin
            n_fail++;
            $display("FAIL left_wall_%0d: got x=%0d moving=%0d, expected x=%0d moving=1",
                     i, bus.pos_x, bus.moving, exp_x[i]);
         end
      end
      n_tests++;
      if (bus.step !== 2'd3) begin
         n_fail++; $display("FAIL left_step: got %0d, expected 3", bus.step);
      end
   endtask

   task automatic test_dir_change();
      reset_dut();
      set_btns(1, 0, 0, 1);
      for (int i = 0; i < 5; i++) do_tick("up_right");
      n_tests++;
      if (bus.start !== 2'd1) begin
         n_fail++; $display("FAIL priority_up: got start=%0d, expected 1", bus.start);
      end
      set_btns(0, 0, 0, 1);
      do_tick("turn_right");
      n_tests++;
      if (bus.start !== 2'd3 || bus.step !== 2'd0) begin
         n_fail++;
         $display("FAIL turn_right: got start=%0d step=%0d, expected start=3 step=0", bus.start, bus.step);
      end
      for (int i = 0; i < 7; i++) do_tick("after_turn");
      n_tests++;
      if (bus.step !== 2'd0) begin
         n_fail++; $display("FAIL div_cleared: got step=%0d, expected 0", bus.step);
      end
      do_tick("after_turn");
      n_tests++;
      if (bus.step !== 2'd1) begin
         n_fail++; $display("FAIL div_wrap: got step=%0d, expected 1", bus.step);
      end
   endtask

   task automatic test_walk_release();
      reset_dut();
      set_btns(0, 1, 0, 0);
      for (int i = 0; i < 20; i++) do_tick("walk_down");
      set_btns(0, 0, 0, 0);
      do_tick("release");
      n_tests++;
      if (bus.moving !== 1'b0 || bus.step !== 2'd0 || bus.start !== 2'd0 || bus.pos_y !== 10'd264) begin
         n_fail++;
         $display("FAIL release: got moving=%0d step=%0d start=%0d y=%0d, expected 0 0 0 264",
                  bus.moving, bus.step, bus.start, bus.pos_y);
      end
   endtask

   task automatic test_reset_mid_walk();
      reset_dut();
      set_btns(0, 1, 0, 0);
      for (int i = 0; i < 17; i++) do_tick("pre_reset");
      n_tests++;
      if (bus.step !== 2'd2) begin
         n_fail++; $display("FAIL pre_reset_step: got %0d, expected 2", bus.step);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      n_tests++;
      if (dut_obs() !== {2'd0, 2'd0, 1'b0, 10'd304, 10'd224}) begin
         n_fail++; $display("FAIL mid_reset: got %h, expected %h", dut_obs(), {2'd0, 2'd0, 1'b0, 10'd304, 10'd224});
      end
      repeat (3) @(posedge clk);
      do_tick("resume");
      n_tests++;
      if (bus.step !== 2'd0 || bus.moving !== 1'b1 || bus.pos_y !== 10'd226) begin
         n_fail++;
         $display("FAIL resume: got step=%0d moving=%0d y=%0d, expected 0 1 226", bus.step, bus.moving, bus.pos_y);
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.frame_tick = 1'b0;
      bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
      model_reset();
      test_reset();
      test_walk_right();
      test_wall_left();
      test_dir_change();
      test_walk_release();
      test_reset_mid_walk();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
